// File: rtl/fetch_unit_if.sv
// Bundle of the instruction-memory bus and the fetch/decode handshake for fetch_unit.
// The master side belongs to the fetch unit and the slave side to memory plus decode.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        pc_src;
   logic [31:0] imm_ext;
   logic        misalign;
   logic [31:0] fetch_count;

   modport master (
      output imem_req, imem_addr, instr, pc, instr_valid, misalign, fetch_count,
      input  imem_ack, imem_rdata, instr_ready, pc_src, imm_ext
   );

   modport slave (
      input  imem_req, imem_addr, instr, pc, instr_valid, misalign, fetch_count,
      output imem_ack, imem_rdata, instr_ready, pc_src, imm_ext
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word, holds it until decode consumes it,
// then moves to pc+4 or a branch target, trapping on a misaligned target.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          clk,
   input logic          reset_n,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {FETCH, HOLD, TRAP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] fetch_pc;
   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic [31:0] count_q;
   logic        armed;
   logic        ack_take;
   logic        handshake;
   logic [31:0] target;

   function automatic logic [31:0] next_pc(input logic [31:0] base,
                                           input logic sel,
                                           input logic signed [31:0] imm);
      next_pc = sel ? base + imm : base + 32'd4;
   endfunction

   assign target = next_pc(pc_q, bus.pc_src, bus.imm_ext);

   // armed stays low for the first edge after reset so an ack racing the release is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= FETCH;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nxt       = state;
      bus.imem_req    = 1'b0;
      bus.instr_valid = 1'b0;
      bus.misalign    = 1'b0;
      ack_take        = 1'b0;
      handshake       = 1'b0;
      case (state)
         FETCH: begin
            bus.imem_req = reset_n;
            ack_take     = armed & bus.imem_ack;
            if (ack_take) state_nxt = HOLD;
         end
         HOLD: begin
            bus.instr_valid = 1'b1;
            handshake       = bus.instr_ready;
            if (handshake) state_nxt = (target[1:0] == 2'b00) ? FETCH : TRAP;
         end
         TRAP: begin
            bus.misalign = 1'b1;
         end
         default: state_nxt = TRAP;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc <= RESET_PC;
         instr_q  <= 32'd0;
         pc_q     <= 32'd0;
         count_q  <= 32'd0;
      end else begin
         if (ack_take) begin
            instr_q <= bus.imem_rdata;
            pc_q    <= fetch_pc;
         end
         if (handshake) begin
            count_q <= count_q + 32'd1;
            if (target[1:0] == 2'b00) fetch_pc <= target;
         end
      end
   end

   assign bus.imem_addr   = fetch_pc;
   assign bus.instr       = instr_q;
   assign bus.pc          = pc_q;
   assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory words are queued when acked and
// matched against instr/pc when the unit presents them to decode.
module tb_fetch_unit;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   applied = 0;
   int   miscompares = 0;
   int   cyc = 0;
   logic [31:0] exp_count = 0;
   logic [63:0] sb[$];

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RPC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      bus.imem_ack = 1'b0;
      bus.instr_ready = 1'b0;
      sb.delete();
      exp_count = 0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // wait for a request, optionally stall, then return one word
   task automatic serve(input int delay, input logic [31:0] word, input logic [31:0] addr);
      int n = 0;
      while (bus.imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      applied++;
      if (bus.imem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL req_timeout: imem_req=%b required 1", bus.imem_req);
         return;
      end
      applied++;
      if (bus.imem_addr !== addr) begin
         miscompares++;
         $display("FAIL imem_addr: got %h required %h", bus.imem_addr, addr);
      end
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         applied++;
         if (bus.imem_addr !== addr || bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_state: addr=%h req=%b valid=%b required %h/1/0",
                     bus.imem_addr, bus.imem_req, bus.instr_valid, addr);
         end
      end
      bus.imem_ack = 1'b1;
      bus.imem_rdata = word;
      sb.push_back({addr, word});
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.imem_rdata = $urandom;
   endtask

   // check the held instruction, stall, handshake, and check the follow-on request
   task automatic consume(input int stall, input logic src, input logic [31:0] imm,
                          output logic [31:0] nxt);
      logic [63:0] e;
      int n = 0;
      nxt = '0;
      while (bus.instr_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      applied++;
      if (bus.instr_valid !== 1'b1 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL valid_timeout: instr_valid=%b queued=%0d required 1", bus.instr_valid, sb.size());
         return;
      end
      e = sb.pop_front();
      applied++;
      if (bus.pc !== e[63:32] || bus.instr !== e[31:0] || bus.imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL held: pc=%h instr=%h req=%b required %h %h 0",
                  bus.pc, bus.instr, bus.imem_req, e[63:32], e[31:0]);
      end
      for (int i = 0; i < stall; i++) begin
         bus.imem_ack = 1'b1;
         bus.imem_rdata = ~e[31:0];
         @(negedge clk);
         applied++;
         if (bus.pc !== e[63:32] || bus.instr !== e[31:0] || bus.instr_valid !== 1'b1 ||
             bus.imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL stall: pc=%h instr=%h valid=%b req=%b required %h %h 1 0",
                     bus.pc, bus.instr, bus.instr_valid, bus.imem_req, e[63:32], e[31:0]);
         end
      end
      bus.imem_ack = 1'b0;
      bus.instr_ready = 1'b1;
      bus.pc_src = src;
      bus.imm_ext = imm;
      nxt = src ? e[63:32] + imm : e[63:32] + 32'd4;
      @(negedge clk);
      bus.instr_ready = 1'b0;
      bus.pc_src = 1'($urandom);
      bus.imm_ext = $urandom;
      exp_count++;
      applied++;
      if (bus.fetch_count !== exp_count) begin
         miscompares++;
         $display("FAIL fetch_count: got %0d required %0d", bus.fetch_count, exp_count);
      end
      applied++;
      if (nxt[1:0] == 2'b00) begin
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== nxt || bus.instr_valid !== 1'b0 ||
             bus.misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL next_fetch: req=%b addr=%h valid=%b mis=%b required 1 %h 0 0",
                     bus.imem_req, bus.imem_addr, bus.instr_valid, bus.misalign, nxt);
         end
      end else if (bus.misalign !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL trap_entry: mis=%b req=%b valid=%b required 1 0 0",
                  bus.misalign, bus.imem_req, bus.instr_valid);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      applied++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.misalign !== 1'b0 ||
          bus.imem_addr !== RPC || bus.instr !== 32'd0 || bus.pc !== 32'd0 ||
          bus.fetch_count !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state: req=%b valid=%b mis=%b addr=%h instr=%h pc=%h cnt=%h",
                  bus.imem_req, bus.instr_valid, bus.misalign, bus.imem_addr,
                  bus.instr, bus.pc, bus.fetch_count);
      end
      @(negedge clk);
      reset_n = 1'b1;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      #1;
      applied++;
      if (bus.imem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL req_after_reset: got %b required 1", bus.imem_req);
      end
      @(negedge clk);
      bus.imem_ack = 1'b0;
      applied++;
      if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.instr !== 32'd0) begin
         miscompares++;
         $display("FAIL release_ack: valid=%b req=%b instr=%h required 0 1 0",
                  bus.instr_valid, bus.imem_req, bus.instr);
      end
      sb.delete();
      exp_count = 0;
   endtask

   task automatic test_sequential();
      logic [31:0] nxt;
      logic [31:0] a = RPC;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         serve(0, 32'h0000_0013, a);
         consume(0, 1'b0, 32'h0, nxt);
         a = nxt;
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] nxt;
      do_reset();
      serve(0, $urandom, RPC);
      consume(0, 1'b0, 32'h0, nxt);
      serve(3, $urandom, 32'h4);
      consume(0, 1'b0, 32'h0, nxt);
   endtask

   task automatic test_branch_and_stall();
      logic [31:0] nxt;
      do_reset();
      serve(0, $urandom, RPC);
      consume(0, 1'b1, 32'h100, nxt);
      serve(0, $urandom, 32'h100);
      consume(0, 1'b1, 32'hFFFF_FFF0, nxt);
      serve(0, $urandom, 32'hF0);
      consume(5, 1'b0, 32'h0, nxt);
      serve(0, $urandom, 32'hF4);
      consume(0, 1'b0, 32'h0, nxt);
   endtask

   task automatic test_misalign();
      logic [31:0] nxt;
      do_reset();
      serve(0, $urandom, RPC);
      consume(0, 1'b1, 32'h10, nxt);
      serve(0, $urandom, 32'h10);
      consume(0, 1'b1, 32'h6, nxt);
      for (int i = 0; i < 4; i++) begin
         bus.imem_ack = 1'b1;
         bus.instr_ready = 1'b1;
         @(negedge clk);
         applied++;
         if (bus.misalign !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_hold: mis=%b req=%b valid=%b required 1 0 0",
                     bus.misalign, bus.imem_req, bus.instr_valid);
         end
      end
      bus.imem_ack = 1'b0;
      bus.instr_ready = 1'b0;
      do_reset();
      applied++;
      if (bus.misalign !== 1'b0 || bus.fetch_count !== 32'd0) begin
         miscompares++;
         $display("FAIL trap_reset: mis=%b cnt=%h required 0 0", bus.misalign, bus.fetch_count);
      end
      serve(0, $urandom, RPC);
      consume(0, 1'b0, 32'h0, nxt);
   endtask

   task automatic test_wrap_and_reset();
      logic [31:0] nxt;
      do_reset();
      serve(0, $urandom, RPC);
      consume(0, 1'b1, 32'hFFFF_FFFC, nxt);
      serve(0, $urandom, 32'hFFFF_FFFC);
      consume(0, 1'b0, 32'h0, nxt);
      serve(0, $urandom, 32'h0);
      consume(0, 1'b0, 32'h0, nxt);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      applied++;
      if (bus.imem_addr !== RPC || bus.fetch_count !== 32'd0 || bus.imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_fetch: addr=%h cnt=%h req=%b required %h 0 0",
                  bus.imem_addr, bus.fetch_count, bus.imem_req, RPC);
      end
      @(negedge clk);
      reset_n = 1'b1;
      sb.delete();
      exp_count = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_hold();
      do_reset();
      serve(0, 32'h1234_5673, RPC);
      #2 reset_n = 1'b0;
      #1;
      applied++;
      if (bus.instr_valid !== 1'b0 || bus.instr !== 32'd0 || bus.pc !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_hold: valid=%b instr=%h pc=%h required 0 0 0",
                  bus.instr_valid, bus.instr, bus.pc);
      end
      @(negedge clk);
      reset_n = 1'b1;
      sb.delete();
      exp_count = 0;
      @(negedge clk);
      applied++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin
         miscompares++;
         $display("FAIL refetch: req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, RPC);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] nxt;
      logic [31:0] a = RPC;
      logic [31:0] imm;
      logic        src;
      int          start;
      do_reset();
      start = cyc;
      for (int i = 0; i < 6; i++) begin
         src = 1'($urandom);
         imm = {20'h0, 8'($urandom), 4'h0};
         serve(0, $urandom, a);
         consume(0, src, imm, nxt);
         a = nxt;
      end
      applied++;
      if (cyc - start !== 12) begin
         miscompares++;
         $display("FAIL throughput: took %0d cycles required 12", cyc - start);
      end
   endtask

   initial begin
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.instr_ready = 1'b0;
      bus.pc_src = 1'b0;
      bus.imm_ext = 32'h0;
      test_reset();
      test_sequential();
      test_wait_states();
      test_branch_and_stall();
      test_misalign();
      test_wrap_and_reset();
      test_reset_hold();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 Parameter RESET_PC, 32'h0000_0000, SHALL be the address of the first fetch after reset.
REQ-003 clk  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  SHALL be the asynchronous active-low reset.
REQ-005 imem_req  out  1  SHALL be the instruction-memory read request.
REQ-006 imem_addr  out  32  SHALL be the fetch address; stable while imem_req=1.
REQ-007 imem_ack  in  1  SHALL mark imem_rdata valid; sampled only while imem_req=1.
REQ-008 imem_rdata  in  32  SHALL be the instruction word returned by memory.
REQ-009 instr  out  32  SHALL be the held instruction; bits [31:7] feed the immediate extender.
REQ-010 pc  out  32  SHALL be the address of the held instruction.
REQ-011 instr_valid  out  1  SHALL indicate that instr and pc are valid.
REQ-012 instr_ready  in  1  SHALL indicate that the downstream decode/execute stage consumes instr this cycle.
REQ-013 pc_src  in  1  SHALL select the branch/jump target for the consumed instruction; 0 selects pc+4.
REQ-014 imm_ext  in  32  SHALL be the sign-extended immediate for the held instruction.
REQ-015 misalign  out  1  SHALL flag a fetch target with bits [1:0] != 0.
REQ-016 fetch_count  out  32  SHALL count consumed instructions.

Function
REQ-017 The FSM SHALL have exactly three states: FETCH, HOLD and TRAP.
REQ-018 FETCH: imem_req=1 and imem_addr=fetch_pc; on a clock edge with imem_ack=1, instr<=imem_rdata, pc<=fetch_pc, next state HOLD.
REQ-019 FETCH with imem_ack=0: hold state and imem_addr unchanged; no timeout.
REQ-020 HOLD: imem_req=0 and instr_valid=1; imem_ack SHALL be ignored.
REQ-021 HOLD with instr_ready=1 (handshake): target = pc_src ? pc+imm_ext : pc+4, modulo 2^32; fetch_count += 1, wrapping at 2^32.
REQ-022 After a handshake, if target[1:0]==0: fetch_pc<=target and next state FETCH; otherwise next state TRAP.
REQ-023 HOLD with instr_ready=0: instr, pc and instr_valid SHALL be held unchanged.
REQ-024 TRAP: misalign=1, imem_req=0, instr_valid=0; the block SHALL remain in TRAP until reset.
REQ-025 pc_src and imm_ext SHALL be sampled only on a handshake cycle; other values are don't-care.
REQ-026 Latency: imem_ack on edge N SHALL give instr_valid=1 from edge N to edge N+1; handshake on edge M SHALL give imem_req=1 in cycle M+1.
REQ-027 Maximum throughput SHALL be one instruction per two cycles with zero-wait memory.
REQ-028 pc+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 with no flag.
REQ-029 instr_valid and imem_req SHALL never be 1 simultaneously.

Reset
REQ-030 On reset_n=0, immediately and independent of clk: state=FETCH, fetch_pc=RESET_PC, instr=0, pc=0, fetch_count=0, misalign=0, instr_valid=0; imem_req=1 once reset_n=1.
REQ-031 Reset asserted mid-fetch or in HOLD SHALL abandon the pending request or held instruction.
REQ-032 imem_ack arriving in the same cycle as reset deassertion SHALL be ignored.

Verification
REQ-033 Reset then zero-wait memory returning 32'h0000_0013, instr_ready=1, pc_src=0 -> imem_addr sequence 0x0, 0x4, 0x8; fetch_count=3 after three handshakes.
REQ-034 Memory with 3-cycle ack delay -> imem_addr stable at 0x4 for 3 cycles; instr_valid asserted only after the ack.
REQ-035 Held instruction at pc=0x100, instr_ready=1, pc_src=1, imm_ext=32'hFFFF_FFF0 -> next imem_addr=0xF0.
REQ-036 instr_ready=0 for 5 cycles in HOLD -> instr, pc and instr_valid unchanged; imem_req=0 throughout.
REQ-037 Handshake with pc=0x10, pc_src=1, imm_ext=0x6 -> misalign=1 and no further imem_req until reset_n pulses low, then fetch from RESET_PC.
REQ-038 pc=0xFFFF_FFFC, pc_src=0, handshake -> next imem_addr=0x0000_0000; reset_n low during a wait -> imem_addr=RESET_PC and fetch_count=0.
